// File: rtl/pipe_pkg.sv
// Shared types for the pipeline controller.
//   stage_ent_t : shadow copy of one in-flight instruction {valid, rd, wr_en}
//   GPR_ZERO    : index of the hard-wired zero register (never a hazard source)
//   mode_t      : per-cycle control decision of pipe_ctrl
// The rd field is sized for the widest supported GPR index; narrower indices
// are zero-extended when they are stored.
package pipe_pkg;

   localparam int RD_W = 8;

   localparam logic [RD_W-1:0] GPR_ZERO = '0;

   typedef struct packed {
      logic            valid;
      logic [RD_W-1:0] rd;
      logic            wr_en;
   } stage_ent_t;

   localparam stage_ent_t BUBBLE = '0;

   typedef enum logic [1:0] {
      MODE_NORMAL,
      MODE_HAZARD,
      MODE_JUMP,
      MODE_FREEZE
   } mode_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline datapath and pipe_ctrl.
//   master : datapath side (drives IDU/EXU/LSU status, receives controls)
//   slave  : pipe_ctrl side
// Inputs  : i_idu_* decode info, i_exu_jmp_en, i_lsu_busy
// Outputs : PC/stage enables, stage flushes, stage valids, perf counters
interface pipe_ctrl_if #(
   parameter int GPRS_WIDTH = 5,
   parameter int CNT_WIDTH  = 32
);
   logic                  i_idu_valid;
   logic [GPRS_WIDTH-1:0] i_idu_rs1_id;
   logic [GPRS_WIDTH-1:0] i_idu_rs2_id;
   logic                  i_idu_rs1_used;
   logic                  i_idu_rs2_used;
   logic [GPRS_WIDTH-1:0] i_idu_rd_id;
   logic                  i_idu_reg_wr_en;
   logic                  i_exu_jmp_en;
   logic                  i_lsu_busy;

   logic                  o_pc_en;
   logic                  o_f2i_en;
   logic                  o_i2e_en;
   logic                  o_e2l_en;
   logic                  o_l2w_en;
   logic                  o_f2i_flush;
   logic                  o_i2e_flush;
   logic                  o_e_valid;
   logic                  o_m_valid;
   logic                  o_w_valid;
   logic [CNT_WIDTH-1:0]  o_stall_cnt;
   logic [CNT_WIDTH-1:0]  o_flush_cnt;

   modport master (
      output i_idu_valid, i_idu_rs1_id, i_idu_rs2_id, i_idu_rs1_used,
             i_idu_rs2_used, i_idu_rd_id, i_idu_reg_wr_en, i_exu_jmp_en,
             i_lsu_busy,
      input  o_pc_en, o_f2i_en, o_i2e_en, o_e2l_en, o_l2w_en, o_f2i_flush,
             o_i2e_flush, o_e_valid, o_m_valid, o_w_valid, o_stall_cnt,
             o_flush_cnt
   );

   modport slave (
      input  i_idu_valid, i_idu_rs1_id, i_idu_rs2_id, i_idu_rs1_used,
             i_idu_rs2_used, i_idu_rd_id, i_idu_reg_wr_en, i_exu_jmp_en,
             i_lsu_busy,
      output o_pc_en, o_f2i_en, o_i2e_en, o_e2l_en, o_l2w_en, o_f2i_flush,
             o_i2e_flush, o_e_valid, o_m_valid, o_w_valid, o_stall_cnt,
             o_flush_cnt
   );
endinterface

// File: rtl/pipe_ctrl_raw_chk.sv
// Read-after-write check of one source register against one shadow entry.
//   src  : source register index read by the IDU instruction
//   used : the instruction actually reads src
//   ent  : shadow entry of a downstream stage
//   hit  : ent will write src and has not done so yet
module raw_chk
   import pipe_pkg::*;
#(
   parameter int GPRS_WIDTH = 5
) (
   input  logic [GPRS_WIDTH-1:0] src,
   input  logic                  used,
   input  stage_ent_t            ent,
   output logic                  hit
);

   logic [RD_W-1:0] src_ext;

   assign src_ext = RD_W'(src);

   // x0 is never written, so a writer targeting it cannot block anyone.
   assign hit = used & ent.valid & ent.wr_en & (ent.rd != GPR_ZERO) &
                (ent.rd == src_ext);

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller for the five-stage core.
// Shadows valid/rd/wr_en of the E, M and W stages, detects RAW interlocks
// (no forwarding, W still counts), resolves EXU jump flushes and LSU
// back-pressure, and drives the PC / stage-register enables and flushes.
//   i_sys_clk   : system clock
//   i_sys_rst_n : asynchronous active-low reset
//   bus         : pipe_ctrl_if slave (decode info in, controls/counters out)
//
// mode        | meaning
// ------------+-----------------------------------------------------------
// MODE_FREEZE | LSU busy: nothing moves, no flush, state and counters hold
// MODE_JUMP   | taken jump in E: flush IF/ID, bubble into E, count flush
// MODE_HAZARD | RAW interlock: hold PC and IF/ID, bubble into E, count stall
// MODE_NORMAL | everything advances, IDU instruction enters E
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int GPRS_WIDTH = 5,
   parameter int CNT_WIDTH  = 32
) (
   input logic        i_sys_clk,
   input logic        i_sys_rst_n,
   pipe_ctrl_if.slave bus
);

   stage_ent_t           ent_e;
   stage_ent_t           ent_m;
   stage_ent_t           ent_w;
   stage_ent_t           ents [3];
   stage_ent_t           ent_idu;
   logic [2:0]           hit_rs1;
   logic [2:0]           hit_rs2;
   logic                 freeze;
   logic                 jump;
   logic                 hazard;
   mode_t                mode;
   logic [CNT_WIDTH-1:0] stall_cnt;
   logic [CNT_WIDTH-1:0] flush_cnt;

   assign ents[0] = ent_e;
   assign ents[1] = ent_m;
   assign ents[2] = ent_w;

   for (genvar s = 0; s < 3; s++) begin : g_raw
      raw_chk #(.GPRS_WIDTH(GPRS_WIDTH)) u_rs1 (
         .src  (bus.i_idu_rs1_id),
         .used (bus.i_idu_rs1_used),
         .ent  (ents[s]),
         .hit  (hit_rs1[s])
      );
      raw_chk #(.GPRS_WIDTH(GPRS_WIDTH)) u_rs2 (
         .src  (bus.i_idu_rs2_id),
         .used (bus.i_idu_rs2_used),
         .ent  (ents[s]),
         .hit  (hit_rs2[s])
      );
   end

   // A jump seen while frozen is simply re-evaluated every cycle; EXU keeps
   // asserting it, so it is taken once on the first unfrozen cycle.
   assign freeze = bus.i_lsu_busy;
   assign jump   = bus.i_exu_jmp_en & ent_e.valid & ~freeze;
   assign hazard = bus.i_idu_valid & ~jump & ~freeze & (|{hit_rs1, hit_rs2});

   always_comb begin
      mode = MODE_NORMAL;
      if (freeze) begin
         mode = MODE_FREEZE;
      end else if (jump) begin
         mode = MODE_JUMP;
      end else if (hazard) begin
         mode = MODE_HAZARD;
      end
   end

   // Controls are gated by reset so the stage registers stay quiet while
   // reset is held, independent of what upstream presents.
   always_comb begin
      bus.o_pc_en     = 1'b0;
      bus.o_f2i_en    = 1'b0;
      bus.o_i2e_en    = 1'b0;
      bus.o_e2l_en    = 1'b0;
      bus.o_l2w_en    = 1'b0;
      bus.o_f2i_flush = 1'b0;
      bus.o_i2e_flush = 1'b0;
      if (i_sys_rst_n) begin
         case (mode)
            MODE_JUMP: begin
               bus.o_pc_en     = 1'b1;
               bus.o_f2i_en    = 1'b1;
               bus.o_i2e_en    = 1'b1;
               bus.o_e2l_en    = 1'b1;
               bus.o_l2w_en    = 1'b1;
               bus.o_f2i_flush = 1'b1;
               bus.o_i2e_flush = 1'b1;
            end
            MODE_HAZARD: begin
               bus.o_i2e_en    = 1'b1;
               bus.o_e2l_en    = 1'b1;
               bus.o_l2w_en    = 1'b1;
               bus.o_i2e_flush = 1'b1;
            end
            MODE_NORMAL: begin
               bus.o_pc_en     = 1'b1;
               bus.o_f2i_en    = 1'b1;
               bus.o_i2e_en    = 1'b1;
               bus.o_e2l_en    = 1'b1;
               bus.o_l2w_en    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign ent_idu = '{valid: bus.i_idu_valid,
                      rd:    RD_W'(bus.i_idu_rd_id),
                      wr_en: bus.i_idu_reg_wr_en};

   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         ent_e <= BUBBLE;
         ent_m <= BUBBLE;
         ent_w <= BUBBLE;
      end else begin
         case (mode)
            MODE_JUMP, MODE_HAZARD: begin
               ent_e <= BUBBLE;
               ent_m <= ent_e;
               ent_w <= ent_m;
            end
            MODE_NORMAL: begin
               ent_e <= ent_idu;
               ent_m <= ent_e;
               ent_w <= ent_m;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (mode == MODE_HAZARD && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
         end
         if (mode == MODE_JUMP && flush_cnt != '1) begin
            flush_cnt <= flush_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign bus.o_e_valid   = ent_e.valid;
   assign bus.o_m_valid   = ent_m.valid;
   assign bus.o_w_valid   = ent_w.valid;
   assign bus.o_stall_cnt = stall_cnt;
   assign bus.o_flush_cnt = flush_cnt;

endmodule
